// File: rtl/risc_pkg.sv
// Shared definitions for the RISC-Net execute stage: opcode map, flag positions,
// execute FSM states and addressing-mode encodings.
package risc_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_NOT = 8'h06;
  localparam logic [7:0] OP_SHL = 8'h07;
  localparam logic [7:0] OP_SHR = 8'h08;
  localparam logic [7:0] OP_MUL = 8'h09;
  localparam logic [7:0] OP_DIV = 8'h0A;
  localparam logic [7:0] OP_CMP = 8'h0B;
  localparam logic [7:0] OP_MOV = 8'h0C;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_REG = 2'b00,
    MODE_IMM = 2'b01,
    MODE_DIR = 2'b10,
    MODE_IND = 2'b11
  } mode_e;

endpackage

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per clock.
// lo/hi present the value the current step produces, so the final step is usable at done.
module mul_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  import risc_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic             run_r;
  logic             div_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_n_s;
  logic [WIDTH-1:0] lo_n_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   sh_s;
  logic [WIDTH:0]   trial_s;

  // One iteration step: hi holds partial product / running remainder
  always_comb begin
    sum_s   = '0;
    sh_s    = '0;
    trial_s = '0;
    hi_n_s  = hi_r;
    lo_n_s  = lo_r;
    if (div_r) begin
      sh_s    = {hi_r, lo_r[WIDTH-1]};
      trial_s = sh_s - {1'b0, b_r};
      if (!trial_s[WIDTH]) begin
        hi_n_s = trial_s[WIDTH-1:0];
        lo_n_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_n_s = sh_s[WIDTH-1:0];
        lo_n_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
      hi_n_s = sum_s[WIDTH:1];
      lo_n_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand load, iteration state and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r <= 1'b0;
      div_r <= 1'b0;
      cnt_r <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      b_r   <= '0;
    end else if (abort) begin
      run_r <= 1'b0;
      cnt_r <= '0;
    end else if (start) begin
      run_r <= 1'b1;
      div_r <= is_div;
      cnt_r <= '0;
      hi_r  <= '0;
      lo_r  <= a;
      b_r   <= b;
    end else if (run_r) begin
      hi_r  <= hi_n_s;
      lo_r  <= lo_n_s;
      cnt_r <= cnt_r + CW'(1);
      run_r <= !done;
    end
  end

  assign done = run_r && (cnt_r == CW'(WIDTH-1));
  assign lo   = lo_n_s;
  assign hi   = hi_n_s;

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU, iterative MUL/DIV control and the registered
// result/flag/write-back outputs feeding the IE/WB latch.
module exec_unit #(
  parameter int WIDTH = 16,
  parameter int OPW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [OPW-1:0]   opcode_in,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] op1_in,
  input  logic [WIDTH-1:0] op2_in,
  output logic             busy,
  output logic             valid_out,
  output logic             wb_en_out,
  output logic [OPW-1:0]   opcode_out,
  output logic [1:0]       mode_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] result_hi_out,
  output logic [3:0]       flags_out,
  output logic             illegal_out
);
  import risc_pkg::*;

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res, input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  state_e           state_r, state_n_s;
  logic             accept_s, start_s, div0_s, done_s, mul_ov_s;
  logic [WIDTH-1:0] md_lo_s, md_hi_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s, alu_v_s;
  logic [WIDTH:0]   sum_s, shl_s, shr_s;
  logic [OPW-1:0]   op_lat_r, op_n_s, op_r;
  logic [1:0]       mode_lat_r, mode_n_s, mode_r;
  logic [WIDTH-1:0] res_n_s, res_r, hi_n_s, hi_r;
  logic [3:0]       flags_n_s, flags_r;
  logic             valid_n_s, valid_r, wb_n_s, wb_r, ill_n_s, ill_r;

  assign div0_s   = (op2_in == '0);
  assign accept_s = (state_r == ST_IDLE) && !flush;
  assign start_s  = accept_s && ((opcode_in == OP_MUL) || ((opcode_in == OP_DIV) && !div0_s));
  assign mul_ov_s = (state_r == ST_MUL) && (md_hi_s != '0);

  mul_div_seq #(.WIDTH(WIDTH)) u_mul_div (
    .clk    (clk),
    .rst    (rst),
    .start  (start_s),
    .is_div (opcode_in == OP_DIV),
    .a      (op1_in),
    .b      (op2_in),
    .abort  (flush),
    .done   (done_s),
    .lo     (md_lo_s),
    .hi     (md_hi_s)
  );

  // Single-cycle ALU; borrow and shift-out come from the extra top/bottom bit
  always_comb begin
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    sum_s     = '0;
    shl_s     = '0;
    shr_s     = '0;
    case (opcode_in)
      OP_ADD: begin
        sum_s     = {1'b0, op1_in} + {1'b0, op2_in};
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (op1_in[WIDTH-1] == op2_in[WIDTH-1]) && (alu_res_s[WIDTH-1] != op1_in[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        sum_s     = {1'b0, op1_in} - {1'b0, op2_in};
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (op1_in[WIDTH-1] != op2_in[WIDTH-1]) && (alu_res_s[WIDTH-1] != op1_in[WIDTH-1]);
      end
      OP_AND: alu_res_s = op1_in & op2_in;
      OP_OR:  alu_res_s = op1_in | op2_in;
      OP_XOR: alu_res_s = op1_in ^ op2_in;
      OP_NOT: alu_res_s = ~op1_in;
      OP_MOV: alu_res_s = op2_in;
      OP_SHL: begin
        shl_s     = {1'b0, op1_in} << op2_in[3:0];
        alu_res_s = shl_s[WIDTH-1:0];
        alu_c_s   = shl_s[WIDTH];
      end
      OP_SHR: begin
        shr_s     = {op1_in, 1'b0} >> op2_in[3:0];
        alu_res_s = shr_s[WIDTH:1];
        alu_c_s   = shr_s[0];
      end
      default: alu_res_s = '0;
    endcase
  end

  // Execute FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Execute FSM next-state logic
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!start_s) begin
          state_n_s = ST_IDLE;
        end else if (opcode_in == OP_DIV) begin
          state_n_s = ST_DIV;
        end else begin
          state_n_s = ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush || done_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = state_r;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Next output register values; result, flags and opcode hold unless an op completes
  always_comb begin
    valid_n_s = 1'b0;
    ill_n_s   = 1'b0;
    op_n_s    = op_r;
    mode_n_s  = mode_r;
    res_n_s   = res_r;
    hi_n_s    = hi_r;
    flags_n_s = flags_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (opcode_in)
            OP_NOP, OP_MUL: valid_n_s = 1'b0;
            OP_DIV: begin
              if (div0_s) begin
                valid_n_s = 1'b1;
                op_n_s    = opcode_in;
                mode_n_s  = mode_in;
                res_n_s   = '1;
                hi_n_s    = op1_in;
                flags_n_s = make_flags('1, 1'b0, 1'b1);
              end else begin
                valid_n_s = 1'b0;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_CMP, OP_MOV: begin
              valid_n_s = 1'b1;
              op_n_s    = opcode_in;
              mode_n_s  = mode_in;
              res_n_s   = alu_res_s;
              hi_n_s    = '0;
              flags_n_s = make_flags(alu_res_s, alu_c_s, alu_v_s);
            end
            default: ill_n_s = 1'b1;
          endcase
        end else begin
          ill_n_s = 1'b0;
        end
      end
      ST_MUL, ST_DIV: begin
        if (!flush && done_s) begin
          valid_n_s = 1'b1;
          op_n_s    = op_lat_r;
          mode_n_s  = mode_lat_r;
          res_n_s   = md_lo_s;
          hi_n_s    = md_hi_s;
          flags_n_s = make_flags(md_lo_s, mul_ov_s, mul_ov_s);
        end else begin
          valid_n_s = 1'b0;
        end
      end
      default: valid_n_s = 1'b0;
    endcase
    wb_n_s = valid_n_s && (op_n_s != OP_CMP);
  end

  // Output registers and the opcode/mode copy held across MUL/DIV iterations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      wb_r       <= 1'b0;
      ill_r      <= 1'b0;
      op_r       <= '0;
      mode_r     <= 2'b00;
      res_r      <= '0;
      hi_r       <= '0;
      flags_r    <= 4'b0000;
      op_lat_r   <= '0;
      mode_lat_r <= 2'b00;
    end else begin
      valid_r <= valid_n_s;
      wb_r    <= wb_n_s;
      ill_r   <= ill_n_s;
      op_r    <= op_n_s;
      mode_r  <= mode_n_s;
      res_r   <= res_n_s;
      hi_r    <= hi_n_s;
      flags_r <= flags_n_s;
      if (start_s) begin
        op_lat_r   <= opcode_in;
        mode_lat_r <= mode_in;
      end
    end
  end

  assign busy          = (state_r != ST_IDLE);
  assign valid_out     = valid_r;
  assign wb_en_out     = wb_r;
  assign illegal_out   = ill_r;
  assign opcode_out    = op_r;
  assign mode_out      = mode_r;
  assign result_out    = res_r;
  assign result_hi_out = hi_r;
  assign flags_out     = flags_r;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed cases plus randomized traffic
// against an arithmetic reference model of the execute stage.
module tb_exec_unit;

  logic        clk, rst, flush;
  logic [7:0]  opcode_in;
  logic [1:0]  mode_in;
  logic [15:0] op1_in, op2_in;
  logic        busy, valid_out, wb_en_out, illegal_out;
  logic [7:0]  opcode_out;
  logic [1:0]  mode_out;
  logic [15:0] result_out, result_hi_out;
  logic [3:0]  flags_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_busy, m_valid, m_wb, m_ill;
  logic [7:0]  m_op;
  logic [1:0]  m_mode;
  logic [15:0] m_res, m_hi;
  logic [3:0]  m_flags;

  exec_unit #(.WIDTH(16), .OPW(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .opcode_in(opcode_in), .mode_in(mode_in),
    .op1_in(op1_in), .op2_in(op2_in), .busy(busy), .valid_out(valid_out),
    .wb_en_out(wb_en_out), .opcode_out(opcode_out), .mode_out(mode_out),
    .result_out(result_out), .result_hi_out(result_hi_out), .flags_out(flags_out),
    .illegal_out(illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [49:0] obs_w = {busy, valid_out, wb_en_out, illegal_out, opcode_out, mode_out,
                       result_out, result_hi_out, flags_out};

  function automatic logic [49:0] exp_vec();
    return {m_busy, m_valid, m_wb, m_ill, m_op, m_mode, m_res, m_hi, m_flags};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
    opcode_in = op;
    mode_in   = md;
    op1_in    = a;
    op2_in    = b;
  endtask

  task automatic model_reset();
    {m_busy, m_valid, m_wb, m_ill, m_op, m_mode, m_res, m_hi, m_flags} = 50'd0;
  endtask

  task automatic model_quiet(input logic bsy);
    m_valid = 1'b0;
    m_wb    = 1'b0;
    m_ill   = 1'b0;
    m_busy  = bsy;
  endtask

  task automatic model_set(input logic [7:0] op, input logic [1:0] md, input logic [15:0] res,
                           input logic [15:0] hi, input logic c, input logic v);
    m_valid = 1'b1;
    m_ill   = 1'b0;
    m_busy  = 1'b0;
    m_op    = op;
    m_mode  = md;
    m_res   = res;
    m_hi    = hi;
    m_flags = {res == 16'h0000, res[15], c, v};
    m_wb    = (op != 8'h0B);
  endtask

  // What the outputs look like one edge after an idle unit samples this op
  task automatic model_accept(input logic [7:0] op, input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
    int s, sa, amt;
    amt = int'(b[3:0]);
    case (op)
      8'h00: model_quiet(1'b0);
      8'h01: begin
        s  = int'(a) + int'(b);
        sa = int'($signed(a)) + int'($signed(b));
        model_set(op, md, 16'(s), 16'h0000, s > 65535, (sa > 32767) || (sa < -32768));
      end
      8'h02, 8'h0B: begin
        s  = int'(a) - int'(b);
        sa = int'($signed(a)) - int'($signed(b));
        model_set(op, md, 16'(s), 16'h0000, a < b, (sa > 32767) || (sa < -32768));
      end
      8'h03: model_set(op, md, a & b, 16'h0000, 1'b0, 1'b0);
      8'h04: model_set(op, md, a | b, 16'h0000, 1'b0, 1'b0);
      8'h05: model_set(op, md, a ^ b, 16'h0000, 1'b0, 1'b0);
      8'h06: model_set(op, md, ~a, 16'h0000, 1'b0, 1'b0);
      8'h0C: model_set(op, md, b, 16'h0000, 1'b0, 1'b0);
      8'h07: model_set(op, md, 16'(int'(a) << amt), 16'h0000,
                       (amt != 0) && (((int'(a) >> (16 - amt)) & 1) == 1), 1'b0);
      8'h08: model_set(op, md, a >> amt, 16'h0000,
                       (amt != 0) && (((int'(a) >> (amt - 1)) & 1) == 1), 1'b0);
      8'h09: model_quiet(1'b1);
      8'h0A: begin
        if (b == 16'h0000) model_set(op, md, 16'hFFFF, a, 1'b0, 1'b1);
        else model_quiet(1'b1);
      end
      default: begin
        model_quiet(1'b0);
        m_ill = 1'b1;
      end
    endcase
  endtask

  task automatic model_finish(input logic [7:0] op, input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    if (op == 8'h09) begin
      p = 32'(a) * 32'(b);
      model_set(op, md, p[15:0], p[31:16], p[31:16] != 16'h0000, p[31:16] != 16'h0000);
    end else begin
      model_set(op, md, a / b, a % b, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    model_reset();
    #2;
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL reset_async got=%h exp=%h", obs_w, exp_vec()); end
    drive(8'h01, 2'b01, 16'h1111, 16'h2222);
    tick();
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", obs_w, exp_vec()); end
    rst = 1'b0;
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    tick();
  endtask

  task automatic test_add_overflow();
    drive(8'h01, 2'b10, 16'h7FFF, 16'h0001);
    tick(); model_accept(8'h01, 2'b10, 16'h7FFF, 16'h0001);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL add_ovf got=%h exp=%h", obs_w, exp_vec()); end
    n_cmp++; if ({result_out, flags_out, valid_out, wb_en_out} !== {16'h8000, 4'b0101, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL add_ovf_const got=%h exp=%h", {result_out, flags_out, valid_out, wb_en_out}, {16'h8000, 4'b0101, 1'b1, 1'b1});
    end
    drive(8'h00, 2'b11, 16'hAAAA, 16'h5555);
    tick(); model_accept(8'h00, 2'b11, 16'hAAAA, 16'h5555);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL nop_hold got=%h exp=%h", obs_w, exp_vec()); end
  endtask

  task automatic test_cmp_shr();
    drive(8'h0B, 2'b00, 16'h0005, 16'h0005);
    tick(); model_accept(8'h0B, 2'b00, 16'h0005, 16'h0005);
    n_cmp++; if ({result_out, flags_out, valid_out, wb_en_out} !== {16'h0000, 4'b1000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL cmp_eq got=%h exp=%h", {result_out, flags_out, valid_out, wb_en_out}, {16'h0000, 4'b1000, 1'b1, 1'b0});
    end
    drive(8'h08, 2'b01, 16'h0003, 16'h0001);
    tick(); model_accept(8'h08, 2'b01, 16'h0003, 16'h0001);
    n_cmp++; if ({result_out, flags_out} !== {16'h0001, 4'b0010}) begin
      n_bad++; $display("FAIL shr_carry got=%h exp=%h", {result_out, flags_out}, {16'h0001, 4'b0010});
    end
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL shr_model got=%h exp=%h", obs_w, exp_vec()); end
  endtask

  task automatic test_random_single();
    logic [7:0] op; logic [1:0] md; logic [15:0] a, b; int r;
    for (int i = 0; i < 120; i++) begin
      r  = int'($urandom_range(0, 14));
      md = 2'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (r <= 8) op = 8'(r);
      else if (r == 9) op = 8'h0B;
      else if (r == 10) op = 8'h0C;
      else if (r == 11) begin op = 8'h0A; b = 16'h0000; end
      else if (r == 12) op = 8'($urandom_range(13, 255));
      else op = 8'($urandom_range(1, 8));
      if ((op == 8'h07 || op == 8'h08) && r > 12) b = 16'(b[3:0]);
      drive(op, md, a, b);
      tick(); model_accept(op, md, a, b);
      n_cmp++; if (obs_w !== exp_vec()) begin
        n_bad++; $display("FAIL rand_single op=%h a=%h b=%h got=%h exp=%h", op, a, b, obs_w, exp_vec());
      end
    end
  endtask

  task automatic test_mul();
    drive(8'h09, 2'b01, 16'h1234, 16'h0010);
    tick(); model_accept(8'h09, 2'b01, 16'h1234, 16'h0010);
    for (int k = 1; k <= 16; k++) begin
      n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL mul_busy k=%0d got=%h exp=%h", k, obs_w, exp_vec()); end
      drive(8'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
      tick();
      if (k == 16) model_finish(8'h09, 2'b01, 16'h1234, 16'h0010);
    end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL mul_done got=%h exp=%h", obs_w, exp_vec()); end
    n_cmp++; if ({busy, result_out, result_hi_out, flags_out} !== {1'b0, 16'h2340, 16'h0001, 4'b0011}) begin
      n_bad++; $display("FAIL mul_const got=%h exp=%h", {busy, result_out, result_hi_out, flags_out}, {1'b0, 16'h2340, 16'h0001, 4'b0011});
    end
  endtask

  task automatic test_div();
    drive(8'h0A, 2'b10, 16'd100, 16'd7);
    tick(); model_accept(8'h0A, 2'b10, 16'd100, 16'd7);
    for (int k = 1; k <= 16; k++) begin
      drive(8'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
      tick();
      if (k == 16) model_finish(8'h0A, 2'b10, 16'd100, 16'd7);
    end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    n_cmp++; if ({result_out, result_hi_out, valid_out, busy} !== {16'd14, 16'd2, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL div_const got=%h exp=%h", {result_out, result_hi_out, valid_out, busy}, {16'd14, 16'd2, 1'b1, 1'b0});
    end
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL div_model got=%h exp=%h", obs_w, exp_vec()); end
  endtask

  task automatic test_div_zero();
    drive(8'h0A, 2'b00, 16'd5, 16'd0);
    tick(); model_accept(8'h0A, 2'b00, 16'd5, 16'd0);
    n_cmp++; if ({busy, valid_out, result_out, result_hi_out, flags_out} !== {1'b0, 1'b1, 16'hFFFF, 16'd5, 4'b0101}) begin
      n_bad++; $display("FAIL div_zero got=%h exp=%h", {busy, valid_out, result_out, result_hi_out, flags_out}, {1'b0, 1'b1, 16'hFFFF, 16'd5, 4'b0101});
    end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    tick(); model_accept(8'h00, 2'b00, 16'h0000, 16'h0000);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL div_zero_after got=%h exp=%h", obs_w, exp_vec()); end
  endtask

  task automatic test_flush();
    drive(8'h09, 2'b11, 16'hBEEF, 16'h1357);
    tick(); model_accept(8'h09, 2'b11, 16'hBEEF, 16'h1357);
    drive(8'h01, 2'b00, 16'h0001, 16'h0001);
    repeat (4) tick();
    flush = 1'b1;
    tick(); flush = 1'b0; model_quiet(1'b0);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL flush_mid got=%h exp=%h", obs_w, exp_vec()); end
    drive(8'h01, 2'b01, 16'h1000, 16'h0234);
    tick(); model_accept(8'h01, 2'b01, 16'h1000, 16'h0234);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL flush_next_add got=%h exp=%h", obs_w, exp_vec()); end
    drive(8'h02, 2'b10, 16'h0003, 16'h0009);
    flush = 1'b1;
    tick(); flush = 1'b0; model_quiet(1'b0);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL flush_drop got=%h exp=%h", obs_w, exp_vec()); end
    drive(8'h0A, 2'b01, 16'hFFFF, 16'h0003);
    tick(); model_accept(8'h0A, 2'b01, 16'hFFFF, 16'h0003);
    repeat (15) tick();
    flush = 1'b1;
    tick(); flush = 1'b0; model_quiet(1'b0);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL flush_final got=%h exp=%h", obs_w, exp_vec()); end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [7:0] op; logic [1:0] md; logic [15:0] a, b, c;
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 8'h09 : 8'h0A;
      md = 2'($urandom);
      a  = 16'($urandom);
      b  = (i == 0) ? 16'h0001 : 16'($urandom_range(1, 65535));
      if (i == 1) b = 16'hFFFF;
      drive(op, md, a, b);
      tick(); model_accept(op, md, a, b);
      for (int k = 1; k <= 16; k++) begin
        drive(8'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
        tick();
        if (k == 16) model_finish(op, md, a, b);
      end
      n_cmp++; if (obs_w !== exp_vec()) begin
        n_bad++; $display("FAIL b2b_multi op=%h a=%h b=%h got=%h exp=%h", op, a, b, obs_w, exp_vec());
      end
      c = 16'($urandom);
      drive(8'h05, md, a, c);
      tick(); model_accept(8'h05, md, a, c);
      n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL b2b_next got=%h exp=%h", obs_w, exp_vec()); end
    end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid();
    drive(8'h0A, 2'b10, 16'd1000, 16'd3);
    tick(); model_accept(8'h0A, 2'b10, 16'd1000, 16'd3);
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=%b", busy, 1'b1); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL rst_mid_async got=%h exp=%h", obs_w, exp_vec()); end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL rst_mid_after got=%h exp=%h", obs_w, exp_vec()); end
  endtask

  task automatic test_illegal();
    drive(8'h0C, 2'b01, 16'h0000, 16'h4321);
    tick(); model_accept(8'h0C, 2'b01, 16'h0000, 16'h4321);
    drive(8'hFF, 2'b10, 16'h1234, 16'h5678);
    tick(); model_accept(8'hFF, 2'b10, 16'h1234, 16'h5678);
    n_cmp++; if ({illegal_out, valid_out, result_out} !== {1'b1, 1'b0, 16'h4321}) begin
      n_bad++; $display("FAIL illegal_pulse got=%h exp=%h", {illegal_out, valid_out, result_out}, {1'b1, 1'b0, 16'h4321});
    end
    drive(8'h00, 2'b00, 16'h0000, 16'h0000);
    tick(); model_accept(8'h00, 2'b00, 16'h0000, 16'h0000);
    n_cmp++; if (obs_w !== exp_vec()) begin n_bad++; $display("FAIL illegal_clear got=%h exp=%h", obs_w, exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_cmp_shr();
    test_random_single();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
